// File: rtl/mbr_pkg.sv
// mbr_pkg -- shared definitions for the multibank frame recorder.
//   DEF_DATA_W / DEF_DEPTH / DEF_NBANK : default word width, words per bank, bank count
//   bank_state_e                       : life cycle of one frame bank
package mbr_pkg;

   localparam int DEF_DATA_W = 128;
   localparam int DEF_DEPTH  = 512;
   localparam int DEF_NBANK  = 2;

   // A bank moves FREE -> FILLING -> READY -> DRAINING -> FREE; a one-word
   // frame skips FILLING and a one-word read skips DRAINING.
   typedef enum logic [1:0] {
      BANK_FREE     = 2'd0,
      BANK_FILLING  = 2'd1,
      BANK_READY    = 2'd2,
      BANK_DRAINING = 2'd3
   } bank_state_e;

endpackage

// File: rtl/mbr_if.sv
// mbr_if -- write/read bus of the multibank frame recorder.
//   din, wr_en, wlast       : write side, driven by the producer
//   wrdy                    : write bank can accept a word
//   rd_en                   : read request from the consumer
//   rrdy                    : a frame is available to read
//   col_data_in/_valid_in   : read data, one cycle after an accepted read
//   col_last                : last word of a frame (with col_valid_in)
//   empty, frames, ovf      : occupancy status and sticky drop flag
interface mbr_if import mbr_pkg::*; #(
   parameter int DATA_W = DEF_DATA_W,
   parameter int NBANK  = DEF_NBANK
);

   logic [DATA_W-1:0]            din;
   logic                         wr_en;
   logic                         wlast;
   logic                         wrdy;
   logic                         rd_en;
   logic                         rrdy;
   logic [DATA_W-1:0]            col_data_in;
   logic                         col_valid_in;
   logic                         col_last;
   logic                         empty;
   logic [$clog2(NBANK+1)-1:0]   frames;
   logic                         ovf;

   modport master (
      output din, wr_en, wlast, rd_en,
      input  wrdy, rrdy, col_data_in, col_valid_in, col_last, empty, frames, ovf
   );

   modport slave (
      input  din, wr_en, wlast, rd_en,
      output wrdy, rrdy, col_data_in, col_valid_in, col_last, empty, frames, ovf
   );

endinterface

// File: rtl/mbr_ram.sv
// mbr_ram -- simple dual-port synchronous RAM with a registered read port.
//   clk, rst       : clock; rst clears only the read register, not the storage
//   i_we/i_waddr/i_wdata : write port
//   i_re/i_raddr   : read port; o_rdata updates one cycle after i_re, holds otherwise
module mbr_ram import mbr_pkg::*; #(
   parameter int DATA_W = DEF_DATA_W,
   parameter int WORDS  = DEF_NBANK * DEF_DEPTH,
   parameter int ADDR_W = $clog2(WORDS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [WORDS];
   logic [DATA_W-1:0] r_rdata;

   // Storage array write; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Registered read; the value is held between reads
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata <= {DATA_W{1'b0}};
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/multibank_rec.sv
// multibank_rec -- records frames of words into NBANK rotating banks and
// replays each complete frame in order.
//   clk, rst : single rising-edge clock, asynchronous active-high reset
//   bus      : mbr_if slave port (write side, read side and status)
module multibank_rec import mbr_pkg::*; #(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int NBANK  = DEF_NBANK
) (
   input  logic  clk,
   input  logic  rst,
   mbr_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int BW = $clog2(NBANK);
   localparam int LW = $clog2(DEPTH + 1);
   localparam int FW = $clog2(NBANK + 1);

   bank_state_e       r_state [NBANK];
   logic [LW-1:0]     r_len   [NBANK];
   logic [BW-1:0]     r_wbank;
   logic [BW-1:0]     r_rbank;
   logic [AW-1:0]     r_waddr;
   logic [AW-1:0]     r_raddr;
   logic [FW-1:0]     r_frames;
   logic              r_empty;
   logic              r_ovf;
   logic              r_col_valid;
   logic              r_col_last;

   logic              w_wrdy;
   logic              w_rrdy;
   logic              w_wacc;
   logic              w_racc;
   logic              w_wclose;
   logic              w_rlast;
   logic              w_drop;
   logic [BW-1:0]     w_wbank_nxt;
   logic [BW-1:0]     w_rbank_nxt;
   logic [FW-1:0]     w_frames_nxt;
   logic [DATA_W-1:0] w_rdata;

   // Ready flags come straight from the state of the bank each pointer targets
   always_comb begin
      w_wrdy = 1'b0;
      w_rrdy = 1'b0;
      case (r_state[r_wbank])
         BANK_FREE, BANK_FILLING: w_wrdy = 1'b1;
         default:                 w_wrdy = 1'b0;
      endcase
      case (r_state[r_rbank])
         BANK_READY, BANK_DRAINING: w_rrdy = 1'b1;
         default:                   w_rrdy = 1'b0;
      endcase
   end

   // Accept, close and drop decisions for the current cycle
   always_comb begin
      w_wacc   = bus.wr_en & w_wrdy;
      w_racc   = bus.rd_en & w_rrdy;
      w_drop   = bus.wr_en & ~w_wrdy;
      w_wclose = w_wacc & (bus.wlast | (r_waddr == AW'(DEPTH - 1)));
      // len is never 0 for a READY/DRAINING bank, so len-1 cannot wrap here
      w_rlast  = w_racc & (LW'(r_raddr) == (r_len[r_rbank] - LW'(1)));
   end

   // Bank pointer wrap and net frame count (a close and a drain cancel out)
   always_comb begin
      w_wbank_nxt  = r_wbank;
      w_rbank_nxt  = r_rbank;
      w_frames_nxt = r_frames;
      if (r_wbank == BW'(NBANK - 1)) begin
         w_wbank_nxt = {BW{1'b0}};
      end else begin
         w_wbank_nxt = r_wbank + BW'(1);
      end
      if (r_rbank == BW'(NBANK - 1)) begin
         w_rbank_nxt = {BW{1'b0}};
      end else begin
         w_rbank_nxt = r_rbank + BW'(1);
      end
      if (w_wclose && !w_rlast) begin
         w_frames_nxt = r_frames + FW'(1);
      end else if (!w_wclose && w_rlast) begin
         w_frames_nxt = r_frames - FW'(1);
      end else begin
         w_frames_nxt = r_frames;
      end
   end

   // Per-bank state and frame length; write and read never target one bank
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < NBANK; b++) begin
            r_state[b] <= BANK_FREE;
            r_len[b]   <= {LW{1'b0}};
         end
      end else begin
         for (int b = 0; b < NBANK; b++) begin
            if (w_wacc && (r_wbank == BW'(b))) begin
               if (w_wclose) begin
                  r_state[b] <= BANK_READY;
                  r_len[b]   <= LW'(r_waddr) + LW'(1);
               end else begin
                  r_state[b] <= BANK_FILLING;
               end
            end else if (w_racc && (r_rbank == BW'(b))) begin
               r_state[b] <= w_rlast ? BANK_FREE : BANK_DRAINING;
            end
         end
      end
   end

   // Write and read pointers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wbank <= {BW{1'b0}};
         r_waddr <= {AW{1'b0}};
         r_rbank <= {BW{1'b0}};
         r_raddr <= {AW{1'b0}};
      end else begin
         if (w_wclose) begin
            r_wbank <= w_wbank_nxt;
            r_waddr <= {AW{1'b0}};
         end else if (w_wacc) begin
            r_waddr <= r_waddr + AW'(1);
         end
         if (w_rlast) begin
            r_rbank <= w_rbank_nxt;
            r_raddr <= {AW{1'b0}};
         end else if (w_racc) begin
            r_raddr <= r_raddr + AW'(1);
         end
      end
   end

   // Registered status and read qualifiers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_frames    <= {FW{1'b0}};
         r_empty     <= 1'b1;
         r_ovf       <= 1'b0;
         r_col_valid <= 1'b0;
         r_col_last  <= 1'b0;
      end else begin
         r_frames    <= w_frames_nxt;
         r_empty     <= (w_frames_nxt == {FW{1'b0}});
         r_ovf       <= r_ovf | w_drop;
         r_col_valid <= w_racc;
         r_col_last  <= w_rlast;
      end
   end

   // Bank index forms the upper address bits, so bank b occupies b*DEPTH..
   mbr_ram #(
      .DATA_W (DATA_W),
      .WORDS  (NBANK * DEPTH),
      .ADDR_W (BW + AW)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_wacc),
      .i_waddr ({r_wbank, r_waddr}),
      .i_wdata (bus.din),
      .i_re    (w_racc),
      .i_raddr ({r_rbank, r_raddr}),
      .o_rdata (w_rdata)
   );

   assign bus.wrdy         = w_wrdy;
   assign bus.rrdy         = w_rrdy;
   assign bus.col_data_in  = w_rdata;
   assign bus.col_valid_in = r_col_valid;
   assign bus.col_last     = r_col_last;
   assign bus.empty        = r_empty;
   assign bus.frames       = r_frames;
   assign bus.ovf          = r_ovf;

endmodule

// File: tb/tb_multibank_rec.sv
// tb_multibank_rec -- directed bench for multibank_rec (DATA_W=16, DEPTH=8, NBANK=2).
// A frame-level model (open frame + queue of completed words) predicts every
// output; a compare process checks it each falling edge, and directed
// sequences add hand-computed literal expectations.
module tb_multibank_rec;

   localparam int DW = 16;
   localparam int DP = 8;
   localparam int NB = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;

   mbr_if #(.DATA_W(DW), .NBANK(NB)) bus ();

   multibank_rec #(.DATA_W(DW), .DEPTH(DP), .NBANK(NB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- frame-level model ----------------
   logic [DW-1:0] m_open [$];
   logic [DW:0]   m_rdq  [$];
   int            m_nfr  = 0;
   bit            m_ovf  = 1'b0;
   bit            m_vout = 1'b0;
   bit            m_lout = 1'b0;
   logic [DW-1:0] m_dout = 16'h0000;

   function automatic bit m_wrdy();
      return (m_open.size() > 0) || (m_nfr < NB);
   endfunction

   function automatic bit m_rrdy();
      return m_nfr > 0;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_open.delete();
         m_rdq.delete();
         m_nfr  = 0;
         m_ovf  = 1'b0;
         m_vout = 1'b0;
         m_lout = 1'b0;
         m_dout = 16'h0000;
      end else begin
         bit wr_ok;
         bit rd_ok;
         logic [DW:0] e;
         wr_ok  = m_wrdy();
         rd_ok  = m_rrdy();
         m_vout = 1'b0;
         m_lout = 1'b0;
         if (bus.rd_en && rd_ok) begin
            e      = m_rdq.pop_front();
            m_vout = 1'b1;
            m_dout = e[DW-1:0];
            m_lout = e[DW];
            if (e[DW]) m_nfr--;
         end
         if (bus.wr_en) begin
            if (wr_ok) begin
               m_open.push_back(bus.din);
               if (bus.wlast || (m_open.size() == DP)) begin
                  for (int i = 0; i < m_open.size(); i++) begin
                     e = {1'b0, m_open[i]};
                     if (i == m_open.size() - 1) e[DW] = 1'b1;
                     m_rdq.push_back(e);
                  end
                  m_nfr++;
                  m_open.delete();
               end
            end else begin
               m_ovf = 1'b1;
            end
         end
      end
   end

   // Compare process: every output against the model on each falling edge
   always @(negedge clk) begin
      chk("wrdy",   32'(bus.wrdy),         32'(m_wrdy()));
      chk("rrdy",   32'(bus.rrdy),         32'(m_rrdy()));
      chk("cvalid", 32'(bus.col_valid_in), 32'(m_vout));
      chk("clast",  32'(bus.col_last),     32'(m_lout));
      chk("cdata",  32'(bus.col_data_in),  32'(m_dout));
      chk("frames", 32'(bus.frames),       32'(m_nfr));
      chk("empty",  32'(bus.empty),        32'(m_nfr == 0));
      chk("ovf",    32'(bus.ovf),          32'(m_ovf));
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input logic we, input logic [DW-1:0] d, input logic wl, input logic re);
      bus.wr_en = we;
      bus.din   = d;
      bus.wlast = wl;
      bus.rd_en = re;
      @(posedge clk);
      #1;
   endtask

   task automatic read_expect(input string name, input logic [DW-1:0] d, input logic last);
      cyc(1'b0, 16'h0000, 1'b0, 1'b1);
      chk({name, "_valid"}, 32'(bus.col_valid_in), 32'd1);
      chk({name, "_data"},  32'(bus.col_data_in),  32'(d));
      chk({name, "_last"},  32'(bus.col_last),     32'(last));
   endtask

   int k;
   int maxf;

   initial begin
      bus.wr_en = 1'b0;
      bus.din   = 16'h0000;
      bus.wlast = 1'b0;
      bus.rd_en = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("rst_wrdy",  32'(bus.wrdy),         32'd1);
      chk("rst_rrdy",  32'(bus.rrdy),         32'd0);
      chk("rst_empty", 32'(bus.empty),        32'd1);
      chk("rst_frames",32'(bus.frames),       32'd0);
      chk("rst_cvalid",32'(bus.col_valid_in), 32'd0);
      chk("rst_cdata", 32'(bus.col_data_in),  32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Full frame closed by address, then read back in order
      for (int i = 0; i < 8; i++) cyc(1'b1, 16'(16'h0010 + i), 1'b0, 1'b0);
      chk("t1_frames", 32'(bus.frames), 32'd1);
      chk("t1_rrdy",   32'(bus.rrdy),   32'd1);
      chk("t1_empty",  32'(bus.empty),  32'd0);
      for (int i = 0; i < 8; i++) read_expect("t1_rd", 16'(16'h0010 + i), 1'(i == 7));
      chk("t1_empty_end",  32'(bus.empty),  32'd1);
      chk("t1_frames_end", 32'(bus.frames), 32'd0);
      cyc(1'b0, 16'h0000, 1'b0, 1'b0);
      chk("t1_idle_valid", 32'(bus.col_valid_in), 32'd0);
      chk("t1_hold_data",  32'(bus.col_data_in),  32'h17);

      // 3-word frame (wlast) followed by a 5-word frame
      for (int i = 0; i < 3; i++) cyc(1'b1, 16'(16'h0020 + i), 1'(i == 2), 1'b0);
      chk("t2_frames_a", 32'(bus.frames), 32'd1);
      for (int i = 0; i < 5; i++) cyc(1'b1, 16'(16'h0030 + i), 1'(i == 4), 1'b0);
      chk("t2_frames_b", 32'(bus.frames), 32'd2);
      chk("t2_wrdy",     32'(bus.wrdy),   32'd0);
      for (int i = 0; i < 3; i++) read_expect("t2_rda", 16'(16'h0020 + i), 1'(i == 2));
      for (int i = 0; i < 5; i++) read_expect("t2_rdb", 16'(16'h0030 + i), 1'(i == 4));
      chk("t2_empty", 32'(bus.empty), 32'd1);

      // Both banks full, 17th write dropped, wrdy back right after a drain
      for (int i = 0; i < 16; i++) cyc(1'b1, 16'(16'h0040 + i), 1'b0, 1'b0);
      chk("t3_wrdy0",  32'(bus.wrdy),   32'd0);
      chk("t3_ovf0",   32'(bus.ovf),    32'd0);
      cyc(1'b1, 16'h0099, 1'b0, 1'b0);
      chk("t3_ovf1",   32'(bus.ovf),    32'd1);
      chk("t3_frames", 32'(bus.frames), 32'd2);
      for (int i = 0; i < 8; i++) read_expect("t3_rda", 16'(16'h0040 + i), 1'(i == 7));
      chk("t3_wrdy1",  32'(bus.wrdy),   32'd1);
      for (int i = 0; i < 8; i++) read_expect("t3_rdb", 16'(16'h0048 + i), 1'(i == 7));
      chk("t3_empty",  32'(bus.empty),  32'd1);

      // Reset in the middle of a partial write and an in-flight read
      for (int i = 0; i < 8; i++) cyc(1'b1, 16'(16'h0060 + i), 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b1, 16'(16'h0050 + i), 1'b0, 1'b1);
      chk("t6_pre_valid", 32'(bus.col_valid_in), 32'd1);
      chk("t6_pre_data",  32'(bus.col_data_in),  32'h63);
      chk("t6_pre_ovf",   32'(bus.ovf),          32'd1);
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      rst = 1'b1;
      #1;
      chk("t6_wrdy",   32'(bus.wrdy),         32'd1);
      chk("t6_rrdy",   32'(bus.rrdy),         32'd0);
      chk("t6_empty",  32'(bus.empty),        32'd1);
      chk("t6_frames", 32'(bus.frames),       32'd0);
      chk("t6_ovf",    32'(bus.ovf),          32'd0);
      chk("t6_cvalid", 32'(bus.col_valid_in), 32'd0);
      chk("t6_clast",  32'(bus.col_last),     32'd0);
      chk("t6_cdata",  32'(bus.col_data_in),  32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) cyc(1'b1, 16'(16'h0070 + i), 1'(i == 2), 1'b0);
      chk("t6_frames_new", 32'(bus.frames), 32'd1);
      for (int i = 0; i < 3; i++) read_expect("t6_rd", 16'(16'h0070 + i), 1'(i == 2));

      // Continuous streaming: write and read every cycle
      k    = 0;
      maxf = 0;
      for (int i = 0; i < 64; i++) begin
         cyc(1'b1, 16'(16'h0100 + i), 1'b0, 1'b1);
         if (int'(bus.frames) > maxf) maxf = int'(bus.frames);
         if (bus.col_valid_in) begin
            chk("t4_stream", 32'(bus.col_data_in), 32'(16'h0100 + k));
            k++;
         end
      end
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, 16'h0000, 1'b0, 1'b1);
         if (bus.col_valid_in) begin
            chk("t4_stream", 32'(bus.col_data_in), 32'(16'h0100 + k));
            k++;
         end
      end
      chk("t4_count",     32'(k),           32'd64);
      chk("t4_maxf_le2",  32'(maxf <= 2),   32'd1);
      chk("t4_no_drop",   32'(bus.ovf),     32'd0);
      chk("t4_empty",     32'(bus.empty),   32'd1);

      // One-word frame
      cyc(1'b1, 16'hAAAA, 1'b1, 1'b0);
      chk("t5_frames", 32'(bus.frames), 32'd1);
      read_expect("t5_rd", 16'hAAAA, 1'b1);
      cyc(1'b0, 16'h0000, 1'b0, 1'b0);
      chk("t5_valid_off", 32'(bus.col_valid_in), 32'd0);
      chk("t5_last_off",  32'(bus.col_last),     32'd0);
      chk("t5_hold",      32'(bus.col_data_in),  32'hAAAA);
      chk("t5_empty",     32'(bus.empty),        32'd1);

      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/multibank_rec.md
MULTIBANK_REC -- requirements
Module: multibank_rec

Interface
REQ-001 SHALL have parameter DATA_W, 128, word width in bits.
REQ-002 SHALL have parameter DEPTH, 512, maximum words per frame (power of two, >=2).
REQ-003 SHALL have parameter NBANK, 2, number of frame banks (>=2).
REQ-004 SHALL have port clk input 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst input 1; reset is asynchronous and active-high.
REQ-006 SHALL have port din input DATA_W, write data.
REQ-007 SHALL have port wr_en input 1, write request.
REQ-008 SHALL have port wlast input 1, marks last word of a frame; qualified by wr_en.
REQ-009 SHALL have port wrdy output 1, write bank can accept a word.
REQ-010 SHALL have port rd_en input 1, read request.
REQ-011 SHALL have port rrdy output 1, a frame is available to read.
REQ-012 SHALL have port col_data_in output DATA_W, read data to array.
REQ-013 SHALL have port col_valid_in output 1, col_data_in valid this cycle.
REQ-014 SHALL have port col_last output 1, qualifies last word of a frame with col_valid_in.
REQ-015 SHALL have port empty output 1, no bank is READY or DRAINING.
REQ-016 SHALL have port frames output $clog2(NBANK+1), count of READY plus DRAINING banks.
REQ-017 SHALL have port ovf output 1, sticky: a write was dropped.

Function
REQ-018 SHALL keep per-bank state FREE, FILLING, READY or DRAINING, plus length len[b] of width $clog2(DEPTH+1).
REQ-019 SHALL keep write bank pointer wbank, write address waddr, read bank pointer rbank, read address raddr; bank pointers wrap NBANK-1 -> 0.
REQ-020 SHALL drive wrdy = 1 iff bank[wbank] is FREE or FILLING (combinational from registered state).
REQ-021 SHALL accept a write when wr_en & wrdy: store din at {wbank,waddr}, bank -> FILLING, waddr +1.
REQ-022 SHALL close the frame when the accepted write has wlast=1 or waddr==DEPTH-1: len[wbank]=waddr+1, bank -> READY, wbank advances, waddr -> 0.
REQ-023 SHALL drop wr_en & !wrdy writes without state change and set ovf until reset.
REQ-024 SHALL drive rrdy = 1 iff bank[rbank] is READY or DRAINING.
REQ-025 SHALL accept a read when rd_en & rrdy: read {rbank,raddr}, bank -> DRAINING, raddr +1; rd_en & !rrdy is ignored.
REQ-026 SHALL present read data with exactly 1-cycle latency: col_valid_in=1 the cycle after an accepted read, else 0; col_data_in holds its value otherwise.
REQ-027 SHALL, on the read of raddr==len[rbank]-1, assert col_last with that word, set bank -> FREE, advance rbank, set raddr -> 0.
REQ-028 SHALL make a freed bank writable on the next cycle (wrdy may rise the cycle after the last read is accepted).
REQ-029 SHALL allow a simultaneous accepted write and accepted read every cycle; these always target different banks.
REQ-030 SHALL support one-word frames (wlast on first word), giving len=1 and col_valid_in with col_last on one cycle.
REQ-031 SHALL drive empty = (frames==0); frames updates the cycle after a frame closes or drains, netting simultaneous events.

Reset
REQ-032 SHALL on rst force all banks FREE, all pointers and len to 0, and wrdy=1, rrdy=0, empty=1, frames=0, ovf=0, col_valid_in=0, col_last=0, col_data_in=0.
REQ-033 SHALL discard any partial frame and any in-flight read on reset mid-operation; RAM contents are not reset.

Structure
REQ-034 SHALL place the bank-state enum and default DATA_W/DEPTH/NBANK constants in shared package mbr_pkg.
REQ-035 SHALL instantiate one sub-module mbr_ram: simple dual-port synchronous RAM of NBANK*DEPTH x DATA_W, 1-cycle registered read.

Verification (bench DATA_W=16, DEPTH=8, NBANK=2)
REQ-036 SHALL cover: 8 writes 0x10..0x17 without wlast -> bank0 READY, frames=1, rrdy=1; 8 reads -> 0x10..0x17 one cycle later each, col_last with 0x17, empty=1.
REQ-037 SHALL cover: frame of 3 words with wlast on 3rd, then frame of 5 -> len 3 and 5; reads show col_last on 3rd and 8th output word.
REQ-038 SHALL cover: fill both banks (16 writes), 17th write -> wrdy=0, word dropped, ovf=1; one full frame read -> wrdy=1 next cycle.
REQ-039 SHALL cover: continuous wr_en and rd_en for 64 cycles -> no drops, output sequence equals input, frames never exceeds 2.
REQ-040 SHALL cover: one-word frame 0xAAAA with wlast -> col_valid_in and col_last together for one cycle, data 0xAAAA.
REQ-041 SHALL cover: rst asserted after 4 of 8 writes and mid-read -> all outputs at reset values immediately, next frame starts at bank0 address 0.
